vector_distance_unit: RTL and testbench
=======================================

VECTOR_DISTANCE_UNIT -- requirements
Module: vector_distance_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning signed element width.
REQ-002 The block SHALL have parameter VEC_LEN, default 8, meaning elements per vector (power of 2, >=2).
REQ-003 The block SHALL have parameter IDX_W, default 16, meaning output vector-index width.
REQ-004 The block SHALL have port ACLK  in  1  single clock; all logic rising-edge.
REQ-005 The block SHALL have port ARESETN  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port q_wr_en  in  1  query-element write strobe.
REQ-007 The block SHALL have port q_wr_addr  in  clog2(VEC_LEN)  query element index.
REQ-008 The block SHALL have port q_wr_data  in  DATA_W  signed query element.
REQ-009 The block SHALL have port s_valid / s_ready  in / out  1 each  candidate element handshake from the vector loader.
REQ-010 The block SHALL have port s_data  in  DATA_W  signed candidate element.
REQ-011 The block SHALL have port s_last  in  1  marks last element of a candidate vector.
REQ-012 The block SHALL have port m_valid / m_ready  out / in  1 each  distance result handshake.
REQ-013 The block SHALL have port m_dist  out  ACC_W = 2*DATA_W+2+clog2(VEC_LEN)  unsigned squared Euclidean distance.
REQ-014 The block SHALL have port m_index  out  IDX_W  ordinal of the candidate vector.
REQ-015 The block SHALL have port err_len  out  1  sticky s_last/count mismatch flag.

Function
REQ-016 The block SHALL accept an element only when s_valid && s_ready are both high in the same cycle.
REQ-017 The block SHALL compute, per accepted element, diff = s_data - query[elem_cnt] at DATA_W+1 bits signed, and sq = diff*diff at 2*DATA_W+2 bits unsigned.
REQ-018 The block SHALL use a 2-stage pipeline: stage 1 registers diff; stage 2 registers sq and adds it into the accumulator.
REQ-019 The block SHALL keep elem_cnt at 0..VEC_LEN-1, incrementing per accepted element and wrapping to 0 after VEC_LEN-1.
REQ-020 The block SHALL define vector boundaries by count only.
REQ-021 The block SHALL set err_len when s_last mismatches (s_last=1 with elem_cnt!=VEC_LEN-1, or s_last=0 with elem_cnt==VEC_LEN-1); processing is unaffected.
REQ-022 The block SHALL, when element VEC_LEN-1 is accepted at cycle t, assert m_valid at t+2 with m_dist equal to the full sum and m_index equal to the vector count, and SHALL clear the accumulator for the next vector with no bubble.
REQ-023 The block SHALL hold m_valid, m_dist and m_index stable until m_valid && m_ready; m_valid SHALL fall the cycle after the handshake unless a new result is ready in the same cycle.
REQ-024 The block SHALL drive s_ready = !(m_valid && !m_ready && a completed vector is in the pipeline), so that no result is ever overwritten or dropped.
REQ-025 The block SHALL increment m_index after each result handshake and wrap from 2^IDX_W-1 to 0.
REQ-026 The block SHALL have a control FSM with states IDLE (elem_cnt=0, pipeline empty), ACCUM (vector in progress or pipeline busy) and HOLD (result waiting, m_ready low).
REQ-027 The FSM SHALL transition IDLE->ACCUM on the first accepted element, ACCUM->HOLD when a result is produced with m_ready low, ACCUM->IDLE when the pipeline is empty and elem_cnt=0, and HOLD->ACCUM/IDLE on the handshake.
REQ-028 The block SHALL honour q_wr_en only in IDLE; writes in other states SHALL be ignored.
REQ-029 ACC_W SHALL be wide enough that no saturation or overflow can occur.

Reset
REQ-030 While ARESETN is low, the block SHALL hold m_valid=0, s_ready=0, m_dist=0, m_index=0, err_len=0, elem_cnt=0, accumulator=0, pipeline valids=0, query=0 and state=IDLE.
REQ-031 The block SHALL drive s_ready=1 from the first clock edge after reset deasserts.
REQ-032 A reset asserted mid-vector SHALL discard the partial sum and any held result.

Structure
REQ-033 Package knn_pkg SHALL hold DATA_W, VEC_LEN, IDX_W, ACC_W and the FSM state enum.
REQ-034 Sub-module vector_sq_diff SHALL implement the diff/square stage 1 with valid pass-through.

Verification
REQ-035 The bench SHALL cover: query all 0, candidate 1..8, s_last on element 8 -> m_dist=204, m_index=0, m_valid 2 cycles after last accept.
REQ-036 The bench SHALL cover: query all 3, candidate all 3 -> m_dist=0; second vector back-to-back -> m_index=1, no idle gap in s_ready.
REQ-037 The bench SHALL cover: query all -32768, candidate all 32767 -> m_dist=34358689800, no overflow.
REQ-038 The bench SHALL cover: m_ready held low 10 cycles while results pend -> s_ready low, m_dist stable, both results delivered in order.
REQ-039 The bench SHALL cover: s_last on element 5 -> err_len=1 and stays 1; sum still emitted after element 8; q_wr_en during ACCUM -> query unchanged.
REQ-040 The bench SHALL cover: ARESETN pulsed low after element 4 -> all outputs 0; next full vector gives the correct sum with m_index=0.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared parameters and control-state encoding for the vector distance unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package knn_pkg;

    localparam int DATA_W  = 16;
    localparam int VEC_LEN = 8;
    localparam int IDX_W   = 16;
    // Squared difference needs 2*DATA_W+2 bits; summing VEC_LEN of them adds clog2(VEC_LEN).
    localparam int ACC_W   = 2 * DATA_W + 2 + $clog2(VEC_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } knn_state_e;

endpackage

// File: rtl/vector_sq_diff.sv
// Stage 1: registers candidate-minus-query difference; squares the registered value.
// Latency: 1 cycle from vld_i to vld_o; sq_o is combinational from the registered diff.
// Backpressure: en_i low freezes the stage (valid, last and diff all hold).
// Ports: clk_i/rst_ni clock and async active-low reset; en_i advance enable;
//        vld_i/last_i/cand_i/query_i incoming element; vld_o/last_o/sq_o stage output.
module vector_sq_diff #(
    parameter int DATA_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  vld_i,
    input  logic                  last_i,
    input  logic [DATA_W-1:0]     cand_i,
    input  logic [DATA_W-1:0]     query_i,
    output logic                  vld_o,
    output logic                  last_o,
    output logic [2*DATA_W+1:0]   sq_o
);

    logic signed [DATA_W:0]     diff_d;
    logic signed [DATA_W:0]     diff_q;
    logic signed [2*DATA_W+1:0] diff_ext;
    logic                       vld_q;
    logic                       last_q;

    // One extra bit so the full signed range difference cannot wrap.
    assign diff_d = $signed({cand_i[DATA_W-1], cand_i}) - $signed({query_i[DATA_W-1], query_i});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            diff_q <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else if (en_i) begin
            vld_q  <= vld_i;
            last_q <= last_i;
            if (vld_i) begin
                diff_q <= diff_d;
            end
        end
    end

    // Square is always non-negative, so the signed product reinterprets cleanly as unsigned.
    assign diff_ext = {{(DATA_W + 1){diff_q[DATA_W]}}, diff_q};
    assign sq_o     = $unsigned(diff_ext * diff_ext);
    assign vld_o    = vld_q;
    assign last_o   = last_q;

endmodule

// File: rtl/vector_distance_unit.sv
// Streams candidate vectors against a stored query and emits the squared Euclidean distance.
// Latency: result m_valid 2 cycles after the last element of a vector is accepted.
// Backpressure: s_ready drops only while a finished vector waits behind an unaccepted result.
// Ports: ACLK/ARESETN clock and async active-low reset; q_wr_* query element write (IDLE only);
//        s_valid/s_ready/s_data/s_last candidate stream; m_valid/m_ready/m_dist/m_index result;
//        err_len sticky s_last vs element-count mismatch.
module vector_distance_unit #(
    parameter int DATA_W  = knn_pkg::DATA_W,
    parameter int VEC_LEN = knn_pkg::VEC_LEN,
    parameter int IDX_W   = knn_pkg::IDX_W
) (
    input  logic                                    ACLK,
    input  logic                                    ARESETN,
    input  logic                                    q_wr_en,
    input  logic [$clog2(VEC_LEN)-1:0]              q_wr_addr,
    input  logic [DATA_W-1:0]                       q_wr_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [DATA_W-1:0]                       s_data,
    input  logic                                    s_last,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [2*DATA_W+2+$clog2(VEC_LEN)-1:0]   m_dist,
    output logic [IDX_W-1:0]                        m_index,
    output logic                                    err_len
);

    import knn_pkg::*;

    localparam int CNT_W = $clog2(VEC_LEN);
    localparam int SQ_W  = 2 * DATA_W + 2;
    localparam int ACC_W = SQ_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

    knn_state_e        state_q, state_d;
    logic [DATA_W-1:0] query_q [VEC_LEN];
    logic [CNT_W-1:0]  elem_cnt_q, elem_cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d, sum;
    logic [ACC_W-1:0]  m_dist_q, m_dist_d;
    logic [IDX_W-1:0]  m_index_q, m_index_d;
    logic              m_valid_q, m_valid_d;
    logic              err_len_q, err_len_d;
    logic              rdy_en_q;
    logic              accept, stall, s1_adv, m_hs, cnt_is_last, busy_next;
    logic              s1_vld, s1_last;
    logic [SQ_W-1:0]   s1_sq;

    assign cnt_is_last = (elem_cnt_q == CNT_LAST);
    assign m_hs        = m_valid_q && m_ready;
    // Only a vector-completing element can collide with a pending result; everything else drains.
    assign stall       = s1_vld && s1_last && m_valid_q && !m_ready;
    // rdy_en_q keeps s_ready low while in reset and lifts it on the first edge afterwards.
    assign s_ready     = rdy_en_q && !stall;
    assign accept      = s_valid && s_ready;
    assign s1_adv      = s1_vld && !stall;
    assign sum         = acc_q + ACC_W'(s1_sq);

    vector_sq_diff #(.DATA_W(DATA_W)) u_sq_diff (
        .clk_i   (ACLK),
        .rst_ni  (ARESETN),
        .en_i    (!stall),
        .vld_i   (accept),
        .last_i  (cnt_is_last),
        .cand_i  (s_data),
        .query_i (query_q[elem_cnt_q]),
        .vld_o   (s1_vld),
        .last_o  (s1_last),
        .sq_o    (s1_sq)
    );

    always_comb begin
        elem_cnt_d = elem_cnt_q;
        acc_d      = acc_q;
        m_dist_d   = m_dist_q;
        m_valid_d  = m_valid_q;
        m_index_d  = m_index_q;
        err_len_d  = err_len_q;
        if (accept) begin
            elem_cnt_d = elem_cnt_q + CNT_W'(1);
            if (s_last != cnt_is_last) begin
                err_len_d = 1'b1;
            end
        end
        if (m_hs) begin
            m_valid_d = 1'b0;
            m_index_d = m_index_q + IDX_W'(1);
        end
        // A finishing element publishes the total and restarts the sum in the same cycle.
        if (s1_adv) begin
            if (s1_last) begin
                acc_d     = '0;
                m_dist_d  = sum;
                m_valid_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

    // Work still outstanding after this edge: a partial vector or an element in stage 1.
    assign busy_next = (elem_cnt_d != '0) || stall || accept;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (m_valid_q && !m_ready)         state_d = ST_HOLD;
                else if (!busy_next && !m_valid_d) state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (m_hs) state_d = (busy_next || m_valid_d) ? ST_ACCUM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= ST_IDLE;
            elem_cnt_q <= '0;
            acc_q      <= '0;
            m_dist_q   <= '0;
            m_valid_q  <= 1'b0;
            m_index_q  <= '0;
            err_len_q  <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_cnt_q <= elem_cnt_d;
            acc_q      <= acc_d;
            m_dist_q   <= m_dist_d;
            m_valid_q  <= m_valid_d;
            m_index_q  <= m_index_d;
            err_len_q  <= err_len_d;
            rdy_en_q   <= 1'b1;
        end
    end

    // Query may only change while no vector is in flight, so in-progress sums stay coherent.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                query_q[i] <= '0;
            end
        end else if (q_wr_en && (state_q == ST_IDLE)) begin
            query_q[q_wr_addr] <= q_wr_data;
        end
    end

    assign m_valid = m_valid_q;
    assign m_dist  = m_dist_q;
    assign m_index = m_index_q;
    assign err_len = err_len_q;

endmodule

// File: tb/tb_vector_distance_unit.sv
// Directed bench for vector_distance_unit with a vector-level reference model.
// Latency: n/a.
// Backpressure: m_ready driven by the directed sequences.
module tb_vector_distance_unit;

    localparam int DW   = 16;
    localparam int VL   = 8;
    localparam int IW   = 16;
    localparam int AW   = 3;
    localparam int ACCW = 2 * DW + 2 + AW;

    logic                 ACLK      = 1'b0;
    logic                 ARESETN   = 1'b0;
    logic                 q_wr_en   = 1'b0;
    logic [AW-1:0]        q_wr_addr = '0;
    logic [DW-1:0]        q_wr_data = '0;
    logic                 s_valid   = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] s_data    = '0;
    logic                 s_last    = 1'b0;
    logic                 m_valid;
    logic                 m_ready   = 1'b1;
    logic [ACCW-1:0]      m_dist;
    logic [IW-1:0]        m_index;
    logic                 err_len;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    longint      qm [VL];
    longint      diff_buf [VL];
    longint      exp_q [$];
    longint      exp_d;
    int          m_ecnt = 0;
    bit          m_err = 1'b0;
    int unsigned m_idx = 0;
    int          hs_cnt = 0;
    longint      last_dist = 0;
    int          last_idx = 0;
    int          stall_cycles = 0;
    bit          prev_vld = 1'b0;
    bit          prev_hs = 1'b0;
    logic [ACCW-1:0] prev_dist = '0;
    logic [IW-1:0]   prev_idx = '0;

    vector_distance_unit #(.DATA_W(DW), .VEC_LEN(VL), .IDX_W(IW)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .q_wr_en   (q_wr_en),
        .q_wr_addr (q_wr_addr),
        .q_wr_data (q_wr_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_dist    (m_dist),
        .m_index   (m_index),
        .err_len   (err_len)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint vec_sqdist();
        longint s = 0;
        for (int i = 0; i < VL; i++) s += diff_buf[i] * diff_buf[i];
        return s;
    endfunction

    // Compare process: every falling edge, check the DUT against the model, then absorb this
    // cycle's accepted element into the model.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            exp_q.delete();
            m_ecnt   = 0;
            m_err    = 1'b0;
            m_idx    = 0;
            prev_vld = 1'b0;
            prev_hs  = 1'b0;
        end else begin
            chk("err_len", err_len, m_err);
            if (prev_vld && !prev_hs) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_dist", m_dist, prev_dist);
                chk("hold_index", m_index, prev_idx);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_result: got dist %0d, expected no result", m_dist);
                end else begin
                    exp_d = exp_q.pop_front();
                    chk("result_dist", m_dist, exp_d);
                    chk("result_index", m_index, m_idx);
                end
                m_idx     = (m_idx + 1) % (1 << IW);
                hs_cnt++;
                last_dist = longint'(m_dist);
                last_idx  = int'(m_index);
            end
            prev_vld  = m_valid;
            prev_hs   = m_valid && m_ready;
            prev_dist = m_dist;
            prev_idx  = m_index;
            if (s_valid && s_ready) begin
                if (s_last != (m_ecnt == VL - 1)) m_err = 1'b1;
                diff_buf[m_ecnt] = longint'(s_data) - qm[m_ecnt];
                if (m_ecnt == VL - 1) begin
                    exp_q.push_back(vec_sqdist());
                    m_ecnt = 0;
                end else begin
                    m_ecnt++;
                end
            end
        end
    end

    task automatic write_q(input int a, input int d, input bit taken);
        q_wr_en   = 1'b1;
        q_wr_addr = AW'(a);
        q_wr_data = DW'(d);
        @(posedge ACLK); #1;
        q_wr_en = 1'b0;
        if (taken) qm[a] = longint'(DW'(d) ^ 16'h8000) - 32768;
    endtask

    task automatic fill_q(input int d);
        for (int i = 0; i < VL; i++) write_q(i, d, 1'b1);
    endtask

    task automatic send_elem(input int d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = DW'(d);
        s_last  = l;
        @(negedge ACLK);
        while (!s_ready && n < 100) begin
            stall_cycles++;
            n++;
            @(negedge ACLK);
        end
        chk("accept_timeout", s_ready, 1'b1);
        @(posedge ACLK); #1;
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_cnt < target && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        chk("result_timeout", hs_cnt >= target, 1'b1);
        @(posedge ACLK);
        @(posedge ACLK); #1;
    endtask

    task automatic do_reset();
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        q_wr_en = 1'b0;
        for (int i = 0; i < VL; i++) qm[i] = 0;
        #3;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_m_dist", m_dist, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_err_len", err_len, 1'b0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        #1;
        chk("s_ready_before_edge", s_ready, 1'b0);
        @(posedge ACLK); #1;
        chk("s_ready_after_edge", s_ready, 1'b1);
    endtask

    initial begin
        int base;
        for (int i = 0; i < VL; i++) qm[i] = 0;
        do_reset();

        // Query 0, candidate 1..8: 1+4+9+...+64 = 204, valid exactly two cycles after last accept.
        base = hs_cnt;
        for (int i = 0; i < VL; i++) send_elem(i + 1, i == VL - 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge ACLK);
        chk("t1_valid_at_t+1", m_valid, 1'b0);
        @(negedge ACLK);
        chk("t1_valid_at_t+2", m_valid, 1'b1);
        chk("t1_dist", m_dist, 204);
        chk("t1_index", m_index, 0);
        wait_hs(base + 1);

        // Query 3, candidate 3, two vectors back-to-back: distance 0, indices 0 then 1, no gap.
        do_reset();
        fill_q(3);
        base = hs_cnt;
        stall_cycles = 0;
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < VL; i++) send_elem(3, i == VL - 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("t2_no_ready_gap", stall_cycles, 0);
        wait_hs(base + 2);
        chk("t2_dist", last_dist, 0);
        chk("t2_index", last_idx, 1);

        // Extreme values: (32767 - (-32768))^2 * 8 = 65535^2 * 8.
        fill_q(-32768);
        base = hs_cnt;
        for (int i = 0; i < VL; i++) send_elem(32767, i == VL - 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_hs(base + 1);
        chk("t3_dist_max", last_dist, 64'd34358689800);

        // Backpressure: two results pend behind m_ready low; 204 must hold, then 204 and 32 in order.
        fill_q(0);
        m_ready = 1'b0;
        base = hs_cnt;
        for (int i = 0; i < VL; i++) send_elem(i + 1, i == VL - 1);
        for (int i = 0; i < VL; i++) send_elem(2, i == VL - 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            chk("t4_s_ready_low", s_ready, 1'b0);
            chk("t4_dist_held", m_dist, 204);
        end
        @(posedge ACLK); #1;
        m_ready = 1'b1;
        wait_hs(base + 2);
        chk("t4_second_dist", last_dist, 32);

        // s_last on element 5 flags err_len; query write mid-vector ignored; sum = 0+1+...+49 = 140.
        fill_q(1);
        base = hs_cnt;
        for (int i = 0; i < 4; i++) send_elem(i + 1, 1'b0);
        s_valid = 1'b0;
        write_q(6, 1000, 1'b0);
        send_elem(5, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge ACLK);
        chk("t5_err_set", err_len, 1'b1);
        @(posedge ACLK); #1;
        for (int i = 5; i < VL; i++) send_elem(i + 1, 1'b0);
        s_valid = 1'b0;
        wait_hs(base + 1);
        chk("t5_dist", last_dist, 140);
        chk("t5_err_sticky", err_len, 1'b1);

        // Reset after element 4 discards the partial vector; next vector restarts at index 0.
        for (int i = 0; i < 4; i++) send_elem(100 * (i + 1), 1'b0);
        s_valid = 1'b0;
        do_reset();
        base = hs_cnt;
        for (int i = 0; i < VL; i++) send_elem(i + 1, i == VL - 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_hs(base + 1);
        chk("t6_dist", last_dist, 204);
        chk("t6_index", last_idx, 0);

        chk("all_results_delivered", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1);
    end

endmodule
